// File: rtl/bcd_cascade_display.sv
// bcd_cascade_display: extends an upstream units counter with tens and hundreds
// BCD digits, flags out-of-range units samples, and time-multiplexes all three
// digits onto a single 7-segment driver.

// One cascaded BCD digit: counts 0..9 on inc and reports its own wrap so the
// next digit up can chain off it.
module bcd_cascade_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       wrap
);

  // Wrap is combinational so the whole chain steps on the same edge.
  assign wrap = inc && (q == 4'd9);

  // Digit register; clear wins over a simultaneous increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= 4'd0;
    else if (clr)  q <= 4'd0;
    else if (wrap) q <= 4'd0;
    else if (inc)  q <= q + 4'd1;
  end

endmodule

module bcd_cascade_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       carry_out,
  output logic       err,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam int         NUM_DIGITS = 2;
  localparam logic [7:0] DIV_LAST   = 8'(SCAN_DIV - 1);

  logic [3:0]                  units_q;
  logic [NUM_DIGITS:0]         inc;
  logic [NUM_DIGITS-1:0][3:0]  digit;
  logic [7:0]                  div_q;
  logic [1:0]                  idx_q;
  logic [3:0]                  sel_digit;

  // A 9 -> 0 step of the units counter is the only thing that advances tens;
  // an invalid units value can never be 9 or 0, so it never forms a rollover.
  assign inc[0] = (units_q == 4'd9) && (count_in == 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_cascade_digit u_digit (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (inc[gi]),
        .q    (digit[gi]),
        .wrap (inc[gi+1])
      );
    end
  endgenerate

  assign tens     = digit[0];
  assign hundreds = digit[1];

  // Units mirror of the upstream counter, one cycle behind count_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) units_q <= 4'd0;
    else     units_q <= count_in;
  end

  // 999 -> 000 pulse; rollovers are at least two cycles apart so it never stretches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_out <= 1'b0;
    else     carry_out <= inc[NUM_DIGITS] && !clr;
  end

  // Sticky out-of-range flag on the sampled units value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  err <= 1'b0;
    else if (clr)             err <= 1'b0;
    else if (count_in > 4'd9) err <= 1'b1;
  end

  // Scan dwell counter and digit index; deliberately untouched by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 8'd0;
      idx_q <= 2'd0;
    end else if (div_q == DIV_LAST) begin
      div_q <= 8'd0;
      idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  // Digit select and segment decode straight from registered state.
  always_comb begin
    an        = 3'b001;
    sel_digit = units_q;
    case (idx_q)
      2'd1:    begin an = 3'b010; sel_digit = tens;     end
      2'd2:    begin an = 3'b100; sel_digit = hundreds; end
      default: begin an = 3'b001; sel_digit = units_q;  end
    endcase
    case (sel_digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_bcd_cascade_display.sv
// Directed bench for bcd_cascade_display with SCAN_DIV = 4.
module tb_bcd_cascade_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       clr = 1'b0;
  logic [3:0] tens, hundreds;
  logic       carry_out, err;
  logic [2:0] an;
  logic [6:0] seg;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int carry_cnt = 0;
  int idx;
  logic [6:0] scan_seg [3];

  bcd_cascade_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .clr(clr),
    .tens(tens), .hundreds(hundreds), .carry_out(carry_out), .err(err),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input pair, take one edge, sample 1 time unit later.
  task automatic cycle(input logic [3:0] v, input logic c);
    count_in = v;
    clr      = c;
    @(posedge clk);
    #1;
    cyc++;
    if (carry_out) carry_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tens"},  tens, 0);
    chk({tag, "_hund"},  hundreds, 0);
    chk({tag, "_carry"}, carry_out, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_an"},    an, 3'b001);
    chk({tag, "_seg"},   seg, 7'h3F);
  endtask

  initial begin
    scan_seg[0] = 7'h07;
    scan_seg[1] = 7'h66;
    scan_seg[2] = 7'h06;

    // Power-on reset
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge clk);
    #3 rst = 1'b0;
    cyc = 0;

    // 25 full decades -> 250
    carry_cnt = 0;
    for (int r = 0; r < 25; r++)
      for (int v = 0; v < 10; v++) cycle(4'(v), 1'b0);
    cycle(4'd0, 1'b0);
    chk("dec_tens", tens, 5);
    chk("dec_hund", hundreds, 2);
    chk("dec_carry_none", carry_cnt, 0);
    chk("dec_err", err, 0);

    // Clear digits
    cycle(4'd0, 1'b1);
    chk("clr_tens", tens, 0);
    chk("clr_hund", hundreds, 0);

    // Build 140 then hold units at 7 and watch the scan
    for (int k = 0; k < 14; k++) begin
      cycle(4'd9, 1'b0);
      cycle(4'd0, 1'b0);
    end
    chk("b141_tens", tens, 4);
    chk("b141_hund", hundreds, 1);
    for (int k = 0; k < 12; k++) begin
      cycle(4'd7, 1'b0);
      idx = (cyc / 4) % 3;
      chk("scan_an", an, 3'b001 << idx);
      chk("scan_seg", seg, scan_seg[idx]);
    end

    // Invalid units sample, landed while units is selected
    for (int k = 0; k < 12 && ((cyc + 1) / 4) % 3 != 0; k++) cycle(4'd7, 1'b0);
    cycle(4'd12, 1'b0);
    chk("inv_err", err, 1);
    chk("inv_an", an, 3'b001);
    chk("inv_seg_blank", seg, 7'h00);
    chk("inv_tens", tens, 4);
    cycle(4'd5, 1'b0);
    chk("inv_err_sticky", err, 1);
    chk("inv_tens_hold", tens, 4);
    cycle(4'd5, 1'b1);
    chk("inv_err_clr", err, 0);

    // Clear beats a coincident rollover
    for (int k = 0; k < 3; k++) begin
      cycle(4'd9, 1'b0);
      cycle(4'd0, 1'b0);
    end
    chk("pri_tens3", tens, 3);
    cycle(4'd9, 1'b0);
    cycle(4'd0, 1'b1);
    chk("pri_tens", tens, 0);
    chk("pri_hund", hundreds, 0);
    chk("pri_carry", carry_out, 0);
    cycle(4'd0, 1'b0);
    chk("pri_carry_next", carry_out, 0);

    // 990 -> 999 -> 000 with one carry pulse
    carry_cnt = 0;
    for (int k = 0; k < 99; k++) begin
      cycle(4'd9, 1'b0);
      cycle(4'd0, 1'b0);
    end
    chk("w_tens9", tens, 9);
    chk("w_hund9", hundreds, 9);
    chk("w_carry_none", carry_cnt, 0);
    cycle(4'd9, 1'b0);
    chk("w_carry_pre", carry_out, 0);
    cycle(4'd0, 1'b0);
    chk("w_tens0", tens, 0);
    chk("w_hund0", hundreds, 0);
    chk("w_carry", carry_out, 1);
    cycle(4'd0, 1'b0);
    chk("w_carry_end", carry_out, 0);

    // Mid-cycle reset with tens = 6
    for (int k = 0; k < 6; k++) begin
      cycle(4'd9, 1'b0);
      cycle(4'd0, 1'b0);
    end
    chk("mr_tens6", tens, 6);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mr");
    #3 rst = 1'b0;
    cyc = 0;

    // After release: no phantom rollover, scan restarts at units, full dwell
    for (int k = 0; k < 6; k++) begin
      cycle(4'd0, 1'b0);
      idx = (cyc / 4) % 3;
      chk("rel_tens", tens, 0);
      chk("rel_an", an, 3'b001 << idx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
